// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that owns the PC.
// Reads pc, fetches over an imem req/ack handshake, loads the IF/ID register
// and drives pc_enable/nextpc. Handles ID stall, flush, branch redirect and
// misaligned-PC faults.
// Optional feature: define FETCH_TIMEOUT_EN to enable the WAIT/DRAIN ack
// timeout (MAX_WAIT cycles); without it the handshake waits indefinitely.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic [31:0] nextpc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_BOOT, S_ISSUE, S_WAIT, S_HOLD, S_DRAIN, S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] hold_reg, hold_next;
  logic        ifid_valid_reg;
  logic [31:0] ifid_instr_reg, ifid_pc_reg, ifid_pc4_reg;
  logic        load;        // write a fetched word into IF/ID this cycle
  logic [31:0] load_instr;
  logic        kill;        // squash IF/ID (redirect or flush)
  logic        accept;      // IF/ID can take a new word at this edge
  logic        timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;

  // Count consecutive cycles spent in WAIT or DRAIN; restart on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if ((state_reg == S_WAIT || state_reg == S_DRAIN) && state_next == state_reg) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  assign timeout = (wait_cnt_reg == CNT_W'(MAX_WAIT - 1)) && !imem_ack;
`else
  logic [31:0] unused_max_wait;
  assign unused_max_wait = 32'(MAX_WAIT);
  assign timeout = 1'b0;
`endif

  assign accept = !ifid_valid_reg || !stall;

  // Next-state, handshake and PC control; redirect beats flush beats normal flow.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    hold_next  = hold_reg;
    load       = 1'b0;
    load_instr = hold_reg;
    kill       = 1'b0;
    pc_enable  = 1'b0;
    nextpc     = pc + 32'd4;
    if (state_reg == S_BOOT) begin
      pc_enable  = 1'b1;
      nextpc     = RESET_VECTOR;
      state_next = S_ISSUE;
    end else if (redirect) begin
      pc_enable = 1'b1;
      nextpc    = redirect_pc;
      kill      = 1'b1;
      if (state_reg == S_WAIT || state_reg == S_DRAIN) begin
        // An outstanding request cannot be aborted; drain it first.
        if (imem_ack) begin
          req_next   = 1'b0;
          state_next = S_ISSUE;
        end else begin
          state_next = S_DRAIN;
        end
      end else begin
        state_next = S_ISSUE;
      end
    end else begin
      kill = flush;
      case (state_reg)
        S_ISSUE: begin
          if (pc[1:0] != 2'b00) begin
            state_next = S_ERR;
          end else begin
            req_next   = 1'b1;
            addr_next  = pc;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            if (imem_ack) begin
              req_next   = 1'b0;
              state_next = S_ISSUE;
            end else begin
              state_next = S_DRAIN;
            end
          end else if (imem_ack) begin
            req_next = 1'b0;
            if (accept) begin
              load       = 1'b1;
              load_instr = imem_rdata;
              pc_enable  = 1'b1;
              state_next = S_ISSUE;
            end else begin
              hold_next  = imem_rdata;
              state_next = S_HOLD;
            end
          end else if (timeout) begin
            req_next   = 1'b0;
            state_next = S_ERR;
          end
        end
        S_HOLD: begin
          if (flush) begin
            // pc was never advanced, so ISSUE refetches the dropped word.
            state_next = S_ISSUE;
          end else if (accept) begin
            load       = 1'b1;
            pc_enable  = 1'b1;
            state_next = S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (imem_ack || timeout) begin
            req_next   = 1'b0;
            state_next = S_ISSUE;
          end
        end
        default: ;  // S_ERR holds until a redirect
      endcase
    end
  end

  // State, fetch request and hold-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_BOOT;
      req_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      hold_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      hold_reg  <= hold_next;
    end
  end

  // IF/ID register: load, squash, consume or freeze under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= 32'd0;
      ifid_pc_reg    <= 32'd0;
      ifid_pc4_reg   <= 32'd0;
    end else if (load) begin
      ifid_valid_reg <= 1'b1;
      ifid_instr_reg <= load_instr;
      ifid_pc_reg    <= addr_reg;
      ifid_pc4_reg   <= addr_reg + 32'd4;
    end else if (kill || !stall) begin
      ifid_valid_reg <= 1'b0;
    end
  end

  assign imem_req   = req_reg;
  assign imem_addr  = addr_reg;
  assign ifid_valid = ifid_valid_reg;
  assign ifid_instr = ifid_instr_reg;
  assign ifid_pc    = ifid_pc_reg;
  assign ifid_pc4   = ifid_pc4_reg;
  assign fetch_err  = (state_reg == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic
// checked against an in-order instruction-stream scoreboard.
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_enable;
  logic [31:0] nextpc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        fetch_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  fetch_unit #(.RESET_VECTOR(RV), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_enable(pc_enable), .nextpc(nextpc),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Program counter register that the fetch unit controls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else if (pc_enable) pc <= nextpc;
  end

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [31:0] exp_pc, req_addr;
  bit          busy;
  int          lat;
  int          consumed;

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; flush = 1'b0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    smp();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", ifid_valid, 0);
    check("rst_err", fetch_err, 0);
    check("rst_pc4", ifid_pc4, 0);

    // Boot and first fetch
    tick(); rst_n = 1'b1;
    smp(); check("boot_en", pc_enable, 1); check("boot_npc", nextpc, RV);
    tick(); smp(); check("issue_pc", pc, RV); check("issue_en", pc_enable, 0);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    smp(); check("t1_req", imem_req, 1); check("t1_addr", imem_addr, RV);
    check("t2_en", pc_enable, 1); check("t2_npc", nextpc, RV + 32'd4);
    tick(); imem_ack = 1'b0; stall = 1'b1;
    smp(); check("t2_valid", ifid_valid, 1); check("t2_instr", ifid_instr, 32'h2008_0005);
    check("t2_pc", ifid_pc, RV); check("t2_pc4", ifid_pc4, RV + 32'd4); check("t2_req", imem_req, 0);

    // Stall into HOLD, then release
    tick(); imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAAA;
    smp(); check("t3_addr", imem_addr, RV + 32'd4); check("t3_en_stall", pc_enable, 0);
    tick(); imem_ack = 1'b0;
    smp(); check("t3_frozen", ifid_instr, 32'h2008_0005); check("t3_hold_en", pc_enable, 0);
    check("t3_hold_req", imem_req, 0);
    tick(); stall = 1'b0;
    smp(); check("t3_rel_en", pc_enable, 1); check("t3_rel_npc", nextpc, RV + 32'd8);
    tick(); smp(); check("t3_instr", ifid_instr, 32'hAAAA_AAAA); check("t3_pc", ifid_pc, RV + 32'd4);

    // Redirect during WAIT, late ack discarded
    tick(); redirect = 1'b1; redirect_pc = RV + 32'h100;
    smp(); check("t4_en", pc_enable, 1); check("t4_npc", nextpc, RV + 32'h100);
    tick(); redirect = 1'b0;
    smp(); check("t4_valid", ifid_valid, 0); check("t4_drain_req", imem_req, 1);
    check("t4_drain_en", pc_enable, 0);
    tick(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    smp(); check("t4_drain_en2", pc_enable, 0);
    tick(); imem_ack = 1'b0;
    smp(); check("t4_late_valid", ifid_valid, 0); check("t4_req0", imem_req, 0);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    smp(); check("t4_addr", imem_addr, RV + 32'h100); check("t4_req1", imem_req, 1);
    tick(); imem_ack = 1'b0;
    smp(); check("t4_instr", ifid_instr, 32'h1111_2222); check("t4_ifpc", ifid_pc, RV + 32'h100);

    // Misaligned PC -> ERR, recovered by redirect
    redirect = 1'b1; redirect_pc = RV + 32'd2;
    smp(); check("t5_en", pc_enable, 1); check("t5_npc", nextpc, RV + 32'd2);
    tick(); redirect = 1'b0;
    smp(); check("t5_kill", ifid_valid, 0);
    tick(); smp(); check("t5_err", fetch_err, 1); check("t5_req", imem_req, 0);
    check("t5_err_en", pc_enable, 0);
    repeat (3) tick();
    smp(); check("t5_err_hold", fetch_err, 1); check("t5_req_hold", imem_req, 0);
    redirect = 1'b1; redirect_pc = RV;
    smp(); check("t5_rec_en", pc_enable, 1); check("t5_rec_npc", nextpc, RV);
    tick(); redirect = 1'b0;
    smp(); check("t5_err_clr", fetch_err, 0);
    tick(); smp(); check("t5_addr", imem_addr, RV); check("t5_req1", imem_req, 1);

    // No ack: timeout or indefinite wait
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick(); smp(); check("t6_wait_req", imem_req, 1);
    end
    tick(); smp(); check("t6_to_req", imem_req, 0); check("t6_to_err", fetch_err, 1);
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick(); imem_ack = 1'b0;
    smp(); check("t6_stray_err", fetch_err, 1); check("t6_stray_valid", ifid_valid, 0);
    redirect = 1'b1; redirect_pc = RV + 32'h200;
    tick(); redirect = 1'b0;
`else
    repeat (100) tick();
    smp(); check("t6_req", imem_req, 1); check("t6_err", fetch_err, 0);
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick(); imem_ack = 1'b0;
`endif

    // pc+4 wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0;
    tick(); imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    smp(); check("wr_addr", imem_addr, 32'hFFFF_FFFC); check("wr_npc", nextpc, 32'd0);
    tick(); imem_ack = 1'b0;
    smp(); check("wr_ifpc", ifid_pc, 32'hFFFF_FFFC); check("wr_pc4", ifid_pc4, 32'd0);

    // Flush in HOLD refetches the same pc; flush in WAIT drains
    tick(); imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    tick(); imem_ack = 1'b0; stall = 1'b1;
    tick(); imem_ack = 1'b1; imem_rdata = 32'h5555_6666;
    smp(); check("fl_addr", imem_addr, 32'd4);
    tick(); imem_ack = 1'b0; flush = 1'b1;
    smp(); check("fl_hold_en", pc_enable, 0);
    tick(); flush = 1'b0;
    smp(); check("fl_valid", ifid_valid, 0);
    stall = 1'b0;
    tick(); smp(); check("fl_refetch", imem_addr, 32'd4); check("fl_req", imem_req, 1);
    flush = 1'b1;
    smp(); check("fl_wait_en", pc_enable, 0);
    tick(); flush = 1'b0;
    smp(); check("fl_drain_req", imem_req, 1); check("fl_drain_en", pc_enable, 0);
    imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
    tick(); imem_ack = 1'b0;
    smp(); check("fl_req0", imem_req, 0); check("fl_drop", ifid_valid, 0);
    tick(); smp(); check("fl_refetch2", imem_addr, 32'd4);

    // Asynchronous reset in WAIT with a live IF/ID
    imem_ack = 1'b1; stall = 1'b1; imem_rdata = 32'h7777_8888;
    tick(); imem_ack = 1'b0;
    tick(); smp(); check("t7_pre_req", imem_req, 1); check("t7_pre_valid", ifid_valid, 1);
    #1 rst_n = 1'b0;
    #1 check("t7_req", imem_req, 0); check("t7_valid", ifid_valid, 0);
    stall = 1'b0;

    // Randomized traffic against the in-order stream scoreboard
    tick(); rst_n = 1'b1;
    exp_pc = RV; busy = 1'b0; lat = 0; consumed = 0; req_addr = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (!imem_req) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          lat = $urandom_range(0, 2);
          req_addr = imem_addr;
        end else begin
          check("rnd_addr_stable", imem_addr, req_addr);
        end
        if (lat == 0) begin
          imem_ack = 1'b1;
          imem_rdata = memf(imem_addr);
        end else begin
          lat--;
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      redirect = (c > 2) && ($urandom_range(0, 24) == 0);
      redirect_pc = RV + ($urandom_range(0, 1023) << 2);
      flush = (c > 2) && !redirect && ($urandom_range(0, 30) == 0);
      smp();
      if (redirect) begin
        check("rnd_rd_en", pc_enable, 1);
        check("rnd_rd_npc", nextpc, redirect_pc);
        exp_pc = redirect_pc;
      end else if (flush) begin
        check("rnd_fl_en", pc_enable, 0);
        if (ifid_valid) exp_pc = exp_pc + 32'd4;
      end else if (ifid_valid && !stall) begin
        check("rnd_pc", ifid_pc, exp_pc);
        check("rnd_instr", ifid_instr, memf(exp_pc));
        check("rnd_pc4", ifid_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      tick();
    end
    check("rnd_progress", 32'(consumed >= 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
